// File: rtl/coherence_msg_router_pkg.sv
// Shared coherence encodings: message types carried on the router/directory
// link and the block states used by the cache-block and directory FSMs.
package coherence_pkg;

  // Message type encoding (directory request channel)
  localparam logic [1:0] MSG_RM  = 2'd0;
  localparam logic [1:0] MSG_WM  = 2'd1;
  localparam logic [1:0] MSG_WB  = 2'd2;
  localparam logic [1:0] MSG_INV = 2'd3;

  // Block state encoding shared by cache-block and directory FSMs
  typedef enum logic [1:0] {
    ST_INVALID  = 2'd0,
    ST_SHARED   = 2'd1,
    ST_MODIFIED = 2'd2
  } blk_state_e;

  // Decoded strobe helper: high when a valid head entry carries type t
  function automatic logic msg_is(input logic vld, input logic [1:0] typ,
                                  input logic [1:0] t);
    return vld && (typ == t);
  endfunction

endpackage

// File: rtl/coherence_msg_router_if.sv
// Router-to-directory request link: valid/ready handshake plus the head
// message fields and their decoded per-type strobes.
interface coherence_msg_router_if #(
  parameter int NODE_W = 1
);
  logic              dir_ready;
  logic              dir_valid;
  logic [1:0]        dir_type;
  logic [NODE_W-1:0] dir_src;
  logic              dir_read_miss;
  logic              dir_write_miss;
  logic              dir_write_back;
  logic              dir_invalidate;

  // Router side drives the message, directory side drives ready
  modport master (
    input  dir_ready,
    output dir_valid, dir_type, dir_src,
    output dir_read_miss, dir_write_miss, dir_write_back, dir_invalidate
  );

  modport slave (
    output dir_ready,
    input  dir_valid, dir_type, dir_src,
    input  dir_read_miss, dir_write_miss, dir_write_back, dir_invalidate
  );
endinterface

// File: rtl/coherence_msg_router_msg_fifo.sv
// Small synchronous FIFO for queued coherence messages. Push is ignored when
// full and pop when empty; full/empty come from the registered count, so a
// pop never makes room for a push in the same cycle and there is no bypass.
module msg_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/coherence_msg_router.sv
// Coherence message router: captures per-node request pulses into pending
// bits, serializes them round-robin through msg_fifo to the directory, and
// registers directory replies back to the addressed nodes.
// Optional build macro ROUTER_STATS_EN enables saturating msg/drop counters;
// without it msg_count and drop_count are tied to zero.
module coherence_msg_router
  import coherence_pkg::*;
#(
  parameter int NODES      = 2,
  parameter int NODE_W     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NODES-1:0]  node_read_miss,
  input  logic [NODES-1:0]  node_write_miss,
  input  logic [NODES-1:0]  node_write_back,
  input  logic [NODES-1:0]  node_invalidate,
  coherence_msg_router_if.master dir,
  input  logic              dir_fetch_in,
  input  logic              dir_inv_in,
  input  logic              dir_reply_in,
  input  logic [NODES-1:0]  dir_dst,
  output logic [NODES-1:0]  node_fetch,
  output logic [NODES-1:0]  node_invalidate_in,
  output logic [NODES-1:0]  node_data_reply,
  output logic              overflow,
  output logic [7:0]        msg_count,
  output logic [7:0]        drop_count
);

  // Pending bits indexed [msg type][node]
  logic [3:0][NODES-1:0] pend_q, pend_d, pulse, clr_mask, drop;
  logic [NODES-1:0]      cand;
  logic [NODE_W-1:0]     rr_ptr_q, sel_node;
  logic [1:0]            sel_type;
  logic                  found, push, pop;
  logic                  fifo_full, fifo_empty;
  logic [NODE_W+1:0]     fifo_dout;
  logic [NODES-1:0]      fetch_q, inv_q, reply_q;
  logic                  overflow_q;

  // Map input pulses onto the type-indexed pending layout
  always_comb begin
    pulse          = '0;
    pulse[MSG_RM]  = node_read_miss;
    pulse[MSG_WM]  = node_write_miss;
    pulse[MSG_WB]  = node_write_back;
    pulse[MSG_INV] = node_invalidate;
  end

  assign cand = pend_q[MSG_RM] | pend_q[MSG_WM] | pend_q[MSG_WB] | pend_q[MSG_INV];

  // Round-robin node search from rr_ptr+1, fixed WB > WM > RM > INV in-node
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    sel_node = '0;
    sel_type = MSG_RM;
    for (int off = 1; off <= NODES; off++) begin
      idx = (int'(rr_ptr_q) + off) % NODES;
      if (!found && cand[idx]) begin
        found    = 1'b1;
        sel_node = NODE_W'(idx);
        if (pend_q[MSG_WB][idx])      sel_type = MSG_WB;
        else if (pend_q[MSG_WM][idx]) sel_type = MSG_WM;
        else if (pend_q[MSG_RM][idx]) sel_type = MSG_RM;
        else                          sel_type = MSG_INV;
      end
    end
  end

  assign push = found && !fifo_full;

  // Clear the granted bit; a same-cycle pulse re-sets it and is not a drop
  always_comb begin
    clr_mask = '0;
    if (push) clr_mask[sel_type][sel_node] = 1'b1;
  end

  assign pend_d = (pend_q & ~clr_mask) | pulse;
  assign drop   = pulse & pend_q & ~clr_mask;

  // Pending bits and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q   <= '0;
      rr_ptr_q <= NODE_W'(NODES-1);
    end else begin
      pend_q <= pend_d;
      if (push) rr_ptr_q <= sel_node;
    end
  end

  msg_fifo #(
    .WIDTH (NODE_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({sel_type, sel_node}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dir.dir_valid      = !fifo_empty;
  assign dir.dir_type       = fifo_dout[NODE_W+1:NODE_W];
  assign dir.dir_src        = fifo_dout[NODE_W-1:0];
  assign dir.dir_read_miss  = msg_is(dir.dir_valid, dir.dir_type, MSG_RM);
  assign dir.dir_write_miss = msg_is(dir.dir_valid, dir.dir_type, MSG_WM);
  assign dir.dir_write_back = msg_is(dir.dir_valid, dir.dir_type, MSG_WB);
  assign dir.dir_invalidate = msg_is(dir.dir_valid, dir.dir_type, MSG_INV);
  assign pop                = dir.dir_valid && dir.dir_ready;

  // Reply routing: one registered cycle, one-cycle pulse per strobe
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_q <= '0;
      inv_q   <= '0;
      reply_q <= '0;
    end else begin
      fetch_q <= {NODES{dir_fetch_in}} & dir_dst;
      inv_q   <= {NODES{dir_inv_in}}   & dir_dst;
      reply_q <= {NODES{dir_reply_in}} & dir_dst;
    end
  end

  assign node_fetch         = fetch_q;
  assign node_invalidate_in = inv_q;
  assign node_data_reply    = reply_q;

  // Sticky lost-pulse flag
  always_ff @(posedge clock) begin
    if (reset)      overflow_q <= 1'b0;
    else if (|drop) overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

`ifdef ROUTER_STATS_EN
  logic [7:0] msg_count_q, drop_count_q;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] count_ones(input logic [4*NODES-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 4*NODES; i++) c = c + {7'd0, v[i]};
    return c;
  endfunction

  // Saturating pop and drop counters
  always_ff @(posedge clock) begin
    if (reset) begin
      msg_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      msg_count_q  <= sat_add8(msg_count_q, {7'd0, pop});
      drop_count_q <= sat_add8(drop_count_q, count_ones(drop));
    end
  end

  assign msg_count  = msg_count_q;
  assign drop_count = drop_count_q;
`else
  assign msg_count  = 8'd0;
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_coherence_msg_router.sv
// Scoreboard bench for coherence_msg_router: stimulus queues expected
// directory messages, a negedge monitor pops and compares on each handshake.
module tb_coherence_msg_router;
  import coherence_pkg::*;

  localparam int NODES = 2, NODE_W = 1, FIFO_DEPTH = 4;

  typedef struct packed {
    logic [1:0]        t;
    logic [NODE_W-1:0] s;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [NODES-1:0] rm, wm, wb, inv, dst;
  logic             f_in, i_in, r_in;
  logic [NODES-1:0] node_fetch, node_inv_in, node_data_reply;
  logic             overflow;
  logic [7:0]       msg_count, drop_count;

  coherence_msg_router_if #(.NODE_W(NODE_W)) dir_bus ();

  coherence_msg_router #(
    .NODES(NODES), .NODE_W(NODE_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .node_read_miss     (rm),
    .node_write_miss    (wm),
    .node_write_back    (wb),
    .node_invalidate    (inv),
    .dir                (dir_bus),
    .dir_fetch_in       (f_in),
    .dir_inv_in         (i_in),
    .dir_reply_in       (r_in),
    .dir_dst            (dst),
    .node_fetch         (node_fetch),
    .node_invalidate_in (node_inv_in),
    .node_data_reply    (node_data_reply),
    .overflow           (overflow),
    .msg_count          (msg_count),
    .drop_count         (drop_count)
  );

  always #5 clock = ~clock;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pops  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] strobes_for(input logic [1:0] t);
    logic [3:0] s;
    s = 4'b0000;
    s[t] = 1'b1;
    return {28'd0, s};
  endfunction

  // Monitor: compare every accepted directory message with the scoreboard
  always @(negedge clock) begin
    if (!reset && dir_bus.dir_valid && dir_bus.dir_ready) begin
      n_pops++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_msg: got type %0d src %0d, expected none",
                 dir_bus.dir_type, dir_bus.dir_src);
      end else begin
        mon_e = sb.pop_front();
        chk("msg_type", 32'(dir_bus.dir_type), 32'(mon_e.t));
        chk("msg_src",  32'(dir_bus.dir_src),  32'(mon_e.s));
        chk("msg_strobes",
            {28'd0, dir_bus.dir_invalidate, dir_bus.dir_write_back,
             dir_bus.dir_write_miss, dir_bus.dir_read_miss},
            strobes_for(mon_e.t));
      end
    end
  end

  task automatic expect_msg(input logic [1:0] t, input int s);
    exp_t e;
    e.t = t;
    e.s = NODE_W'(s);
    sb.push_back(e);
  endtask

  task automatic pulse(input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] c, input logic [1:0] d);
    rm = a; wm = b; wb = c; inv = d;
    @(posedge clock); #1;
    rm = '0; wm = '0; wb = '0; inv = '0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clock);
    @(posedge clock); #1;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d messages outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_counters(input int exp_msgs, input int exp_drops);
`ifdef ROUTER_STATS_EN
    chk("msg_count",  32'(msg_count),  32'(exp_msgs));
    chk("drop_count", 32'(drop_count), 32'(exp_drops));
`else
    chk("msg_count",  32'(msg_count),  32'(0 * exp_msgs));
    chk("drop_count", 32'(drop_count), 32'(0 * exp_drops));
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rm = '0; wm = '0; wb = '0; inv = '0; dst = '0;
    f_in = 1'b0; i_in = 1'b0; r_in = 1'b0;
    dir_bus.dir_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_valid",    32'(dir_bus.dir_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_fetch",    32'(node_fetch), 0);
    chk_counters(0, 0);

    // Single message with latency check
    @(posedge clock); #1;
    dir_bus.dir_ready = 1'b1;
    expect_msg(MSG_RM, 0);
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    @(negedge clock);
    chk("latency_pending_only", 32'(dir_bus.dir_valid), 0);
    @(negedge clock);
    chk("latency_valid",  32'(dir_bus.dir_valid), 1);
    chk("latency_rm_stb", 32'(dir_bus.dir_read_miss), 1);
    @(negedge clock);
    chk("single_drained", 32'(dir_bus.dir_valid), 0);
    @(posedge clock); #1;
    chk_counters(1, 0);

    // Write back precedes write miss on the same node
    expect_msg(MSG_WB, 1);
    expect_msg(MSG_WM, 1);
    pulse(2'b00, 2'b10, 2'b10, 2'b00);
    wait_drain(20);

    // Round-robin: rr at node 1 -> 0 first; then after a node-0 grant -> 1 first
    expect_msg(MSG_RM, 0);
    expect_msg(MSG_RM, 1);
    pulse(2'b11, 2'b00, 2'b00, 2'b00);
    wait_drain(20);
    repeat (10) @(posedge clock);
    #1;
    expect_msg(MSG_RM, 0);
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    wait_drain(20);
    expect_msg(MSG_RM, 1);
    expect_msg(MSG_RM, 0);
    pulse(2'b11, 2'b00, 2'b00, 2'b00);
    wait_drain(20);

    // Backpressure: 5 pending, FIFO takes 4 (rr at node 0 -> node 1 first)
    dir_bus.dir_ready = 1'b0;
    expect_msg(MSG_WM, 1);
    expect_msg(MSG_WB, 0);
    expect_msg(MSG_RM, 1);
    expect_msg(MSG_WM, 0);
    expect_msg(MSG_RM, 0);
    pulse(2'b11, 2'b11, 2'b01, 2'b00);
    repeat (8) @(posedge clock);
    #1;
    chk("bp_valid", 32'(dir_bus.dir_valid), 1);
    chk("bp_no_overflow", 32'(overflow), 0);
    pulse(2'b01, 2'b00, 2'b00, 2'b00);
    @(negedge clock);
    chk("overflow_set", 32'(overflow), 1);
    chk_counters(n_pops, 1);
    @(posedge clock); #1;
    dir_bus.dir_ready = 1'b1;
    wait_drain(40);
    chk("overflow_sticky", 32'(overflow), 1);
    chk_counters(n_pops, 1);

    // Reply routing
    i_in = 1'b1; dst = 2'b11;
    @(posedge clock); #1;
    i_in = 1'b0; dst = 2'b00;
    @(negedge clock);
    chk("inv_route",    32'(node_inv_in), 32'h3);
    chk("inv_no_fetch", 32'(node_fetch), 0);
    chk("inv_no_reply", 32'(node_data_reply), 0);
    @(negedge clock);
    chk("inv_one_cycle", 32'(node_inv_in), 0);
    @(posedge clock); #1;
    r_in = 1'b1; dst = 2'b01;
    @(posedge clock); #1;
    r_in = 1'b0; dst = 2'b00;
    @(negedge clock);
    chk("reply_route",  32'(node_data_reply), 32'h1);
    chk("reply_no_inv", 32'(node_inv_in), 0);
    @(negedge clock);
    chk("reply_one_cycle", 32'(node_data_reply), 0);

    // Reset mid-operation discards queued and pending messages
    @(posedge clock); #1;
    dir_bus.dir_ready = 1'b0;
    pulse(2'b11, 2'b01, 2'b00, 2'b00);
    repeat (6) @(posedge clock);
    #1;
    chk("pre_reset_valid", 32'(dir_bus.dir_valid), 1);
    reset = 1'b1;
    rm = 2'b10;
    @(posedge clock); #1;
    reset = 1'b0;
    rm = 2'b00;
    @(negedge clock);
    chk("mid_rst_valid",    32'(dir_bus.dir_valid), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk_counters(0, 0);
    repeat (4) @(negedge clock);
    chk("rst_cycle_input_ignored", 32'(dir_bus.dir_valid), 0);
    @(posedge clock); #1;
    dir_bus.dir_ready = 1'b1;
    expect_msg(MSG_RM, 1);
    pulse(2'b10, 2'b00, 2'b00, 2'b00);
    @(negedge clock);
    chk("post_rst_pending_only", 32'(dir_bus.dir_valid), 0);
    @(negedge clock);
    chk("post_rst_valid", 32'(dir_bus.dir_valid), 1);
    wait_drain(20);

    // After reset rr favours node 0; WM outranks INV within a node
    expect_msg(MSG_WM, 0);
    expect_msg(MSG_RM, 1);
    expect_msg(MSG_INV, 0);
    pulse(2'b10, 2'b01, 2'b00, 2'b01);
    wait_drain(20);

    chk("final_queue_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
